// File: rtl/muldiv_if.sv
// ============================================================================
//  Module   : muldiv_if
//  Purpose  : EX-stage <-> multiply/divide engine handshake bundle.
//             Carries the start/annul request and the busy/ready/result reply.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_if #(
  parameter int WIDTH = 32
) ();

  logic               start_i;
  logic [2:0]         op_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic [2*WIDTH-1:0] hilo_i;
  logic               annul_i;
  logic               busy_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;

  // EX stage side: issues requests, consumes results
  modport master (
    output start_i, op_i, opdata1_i, opdata2_i, hilo_i, annul_i,
    input  busy_o, ready_o, result_o
  );

  // Engine side
  modport slave (
    input  start_i, op_i, opdata1_i, opdata2_i, hilo_i, annul_i,
    output busy_o, ready_o, result_o
  );

endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative multiply / multiply-accumulate / divide engine.
//             Shift-add multiply and restoring radix-2 divide on operand
//             magnitudes, followed by a single sign/accumulate fix-up cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic clk,
  input  wire logic rst,
  muldiv_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic [WIDTH-1:0]  mag_a;
  logic [WIDTH-1:0]  mag_b;
  logic              neg_res;
  logic              neg_rem;
  logic [W2-1:0]     hilo;
  logic [W2-1:0]     acc;
  logic [W2-1:0]     fix_res;
  logic              busy_q;
  logic              ready_q;
  logic [W2-1:0]     result_q;

  // Request decode: sign handling, magnitudes and the divide-by-zero answer
  logic              in_signed;
  logic              in_div;
  logic              a_neg;
  logic              b_neg;
  logic [WIDTH-1:0]  abs_a;
  logic [WIDTH-1:0]  abs_b;
  logic [WIDTH-1:0]  div0_quot;

  always_comb begin
    in_signed = ~bus.op_i[0];
    in_div    = &bus.op_i[2:1];
    a_neg     = in_signed & bus.opdata1_i[WIDTH-1];
    b_neg     = in_signed & bus.opdata2_i[WIDTH-1];
    abs_a     = a_neg ? -bus.opdata1_i : bus.opdata1_i;
    abs_b     = b_neg ? -bus.opdata2_i : bus.opdata2_i;
    // Signed negative dividend gives quotient 1, everything else all-ones
    div0_quot = a_neg ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b1}};
  end

  // One iteration step: acc holds {partial, multiplier} or {remainder, dividend/quotient}
  logic              op_div;
  logic [WIDTH:0]    mul_sum;
  logic [W2-1:0]     mul_next;
  logic [WIDTH:0]    div_top;
  logic [WIDTH:0]    div_diff;
  logic [W2-1:0]     div_next;

  always_comb begin
    op_div   = &op[2:1];
    mul_sum  = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    div_top  = acc[W2-1:WIDTH-1];
    div_diff = div_top - {1'b0, mag_b};
    // Borrow out means the divisor did not fit: shift in a zero quotient bit
    div_next = div_diff[WIDTH] ? {acc[W2-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Fix-up: restore signs and apply the accumulate/subtract for MADD/MSUB
  logic [W2-1:0]     prod;
  logic [WIDTH-1:0]  quot;
  logic [WIDTH-1:0]  rem;
  logic [W2-1:0]     fix_next;

  always_comb begin
    prod = neg_res ? -acc : acc;
    quot = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_rem ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
    case (op[2:1])
      2'b01:   fix_next = hilo + prod;
      2'b10:   fix_next = hilo - prod;
      2'b11:   fix_next = {rem, quot};
      default: fix_next = prod;
    endcase
  end

  // Control FSM with registered busy/ready/result
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op       <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      hilo     <= '0;
      acc      <= '0;
      fix_res  <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i && !bus.annul_i) begin
            op      <= bus.op_i;
            mag_a   <= abs_a;
            mag_b   <= abs_b;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            hilo    <= bus.hilo_i;
            acc     <= {{WIDTH{1'b0}}, (in_div ? abs_a : abs_b)};
            cnt     <= '0;
            busy_q  <= 1'b1;
            if (in_div && (bus.opdata2_i == '0)) begin
              fix_res <= {bus.opdata1_i, div0_quot};
              state   <= DONE;
            end else begin
              state   <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.annul_i) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            acc <= op_div ? div_next : mul_next;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          if (bus.annul_i) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            fix_res <= fix_next;
            state   <= DONE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          if (!bus.annul_i) begin
            ready_q  <= 1'b1;
            result_q <= fix_res;
          end
        end
      endcase
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.ready_o  = ready_q;
  assign bus.result_o = result_q;

endmodule

`default_nettype wire
